// File: rtl/fsk_bit_serializer.sv
// FSK bit serializer: frames a payload word (start, LSB-first data, optional
// parity, stop bits) onto tone_sel, advancing one bit per rising edge of baud_clk.
module fsk_bit_serializer #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk_in,
    input  logic                 reset_n,
    input  logic                 baud_clk,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic                 tone_sel,
    output logic                 tx_busy,
    output logic                 frame_done
);

    localparam int            CW        = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);
    localparam logic          PAR_INV   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {IDLE, WAIT_TICK, START, DATA, PARITY, STOP} state_t;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] sr_q, sr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 par_q, par_d;
    logic                 pend_q, pend_d;
    logic                 tone_q, tone_d;
    logic                 done_q, done_d;
    logic                 baud_q;
    logic                 baud_tick, last_stop, accept;

    assign baud_tick  = baud_clk & ~baud_q;
    assign last_stop  = (state_q == STOP) && (cnt_q == LAST_STOP);
    // Once a follow-on word is parked during the final stop bit, stop accepting.
    assign data_ready = (state_q == IDLE) || (last_stop && !pend_q);
    assign accept     = data_valid && data_ready;
    assign tone_sel   = tone_q;
    assign tx_busy    = (state_q != IDLE);
    assign frame_done = done_q;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        pend_d  = pend_q;
        tone_d  = tone_q;
        done_d  = 1'b0;

        if (accept) begin
            sr_d   = data_in;
            par_d  = (^data_in) ^ PAR_INV;
            pend_d = (state_q == STOP);
        end

        case (state_q)
            IDLE: begin
                // A tick coinciding with acceptance is deliberately not counted.
                if (accept) state_d = WAIT_TICK;
            end
            WAIT_TICK: begin
                if (baud_tick) begin
                    state_d = START;
                    tone_d  = 1'b0;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_d = DATA;
                    tone_d  = sr_q[0];
                    cnt_d   = '0;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (cnt_q == LAST_DATA) begin
                        cnt_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            tone_d  = par_q;
                        end else begin
                            state_d = STOP;
                            tone_d  = 1'b1;
                        end
                    end else begin
                        cnt_d  = cnt_q + CW'(1);
                        sr_d   = sr_q >> 1;
                        tone_d = sr_q[1];
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    state_d = STOP;
                    tone_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (last_stop) begin
                        done_d = 1'b1;
                        cnt_d  = '0;
                        if (pend_q || accept) begin
                            state_d = START;
                            tone_d  = 1'b0;
                            pend_d  = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            pend_q  <= 1'b0;
            tone_q  <= 1'b1;
            done_q  <= 1'b0;
            baud_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            pend_q  <= pend_d;
            tone_q  <= tone_d;
            done_q  <= done_d;
            baud_q  <= baud_clk;
        end
    end

endmodule

// File: tb/tb_fsk_bit_serializer.sv
// Bench for fsk_bit_serializer: four parameterisations share one stimulus stream
// and are tracked by a frame-level bit-queue model checked every cycle.
module tb_fsk_bit_serializer;

    localparam int ND = 4;
    localparam int P_DB [ND] = '{8, 8, 8, 5};
    localparam int P_PE [ND] = '{0, 1, 1, 0};
    localparam int P_PO [ND] = '{0, 0, 1, 0};
    localparam int P_SB [ND] = '{1, 1, 1, 2};

    logic          clk_in = 1'b0, reset_n = 1'b0, baud_clk = 1'b0, data_valid = 1'b0;
    logic [7:0]    data_in = 8'h00;
    logic [ND-1:0] rdy_w, tone_w, busy_w, done_w;

    always #80 clk_in = ~clk_in;

    fsk_bit_serializer #(.DATA_BITS(8)) u_d0 (
        .clk_in(clk_in), .reset_n(reset_n), .baud_clk(baud_clk), .data_in(data_in),
        .data_valid(data_valid), .data_ready(rdy_w[0]), .tone_sel(tone_w[0]),
        .tx_busy(busy_w[0]), .frame_done(done_w[0]));
    fsk_bit_serializer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_d1 (
        .clk_in(clk_in), .reset_n(reset_n), .baud_clk(baud_clk), .data_in(data_in),
        .data_valid(data_valid), .data_ready(rdy_w[1]), .tone_sel(tone_w[1]),
        .tx_busy(busy_w[1]), .frame_done(done_w[1]));
    fsk_bit_serializer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1)) u_d2 (
        .clk_in(clk_in), .reset_n(reset_n), .baud_clk(baud_clk), .data_in(data_in),
        .data_valid(data_valid), .data_ready(rdy_w[2]), .tone_sel(tone_w[2]),
        .tx_busy(busy_w[2]), .frame_done(done_w[2]));
    fsk_bit_serializer #(.DATA_BITS(5), .STOP_BITS(2)) u_d3 (
        .clk_in(clk_in), .reset_n(reset_n), .baud_clk(baud_clk), .data_in(data_in[4:0]),
        .data_valid(data_valid), .data_ready(rdy_w[3]), .tone_sel(tone_w[3]),
        .tx_busy(busy_w[3]), .frame_done(done_w[3]));

    // Reference model: per DUT, a queue of line bits still to be sent.
    logic [31:0] m_bits [ND];
    logic [31:0] m_last [ND];
    int          m_len [ND], m_nacc [ND], obs_done [ND], acc_tgt [ND];
    logic        m_busy [ND], m_cur [ND], m_curlast [ND], m_done [ND];
    logic        m_bprev;
    int          m_ticks, n_chk, n_err, bmode, bcnt;
    bit          auto_drop;

    function automatic logic m_ready(input int d);
        return !m_busy[d] || (m_curlast[d] && m_len[d] == 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            m_len[d] = 0; m_busy[d] = 1'b0; m_cur[d] = 1'b1;
            m_curlast[d] = 1'b0; m_done[d] = 1'b0;
        end
        m_bprev = 1'b0;
    endtask

    task automatic push_frame(input int d, input logic [7:0] w);
        int   n;
        logic p;
        n = m_len[d];
        p = 1'b0;
        m_bits[d][n] = 1'b0; m_last[d][n] = 1'b0; n++;
        for (int i = 0; i < P_DB[d]; i++) begin
            m_bits[d][n] = w[i]; m_last[d][n] = 1'b0; p = p ^ w[i]; n++;
        end
        if (P_PE[d] != 0) begin
            m_bits[d][n] = p ^ (P_PO[d] != 0); m_last[d][n] = 1'b0; n++;
        end
        for (int s = 0; s < P_SB[d]; s++) begin
            m_bits[d][n] = 1'b1; m_last[d][n] = (s == P_SB[d] - 1); n++;
        end
        m_len[d] = n;
    endtask

    task automatic pop(input int d);
        m_cur[d]     = m_bits[d][0];
        m_curlast[d] = m_last[d][0];
        m_bits[d]    = m_bits[d] >> 1;
        m_last[d]    = m_last[d] >> 1;
        m_len[d]--;
    endtask

    task automatic model_step();
        logic tick, was_busy;
        if (!reset_n) begin
            model_reset();
            return;
        end
        tick    = baud_clk && !m_bprev;
        m_bprev = baud_clk;
        if (tick) m_ticks++;
        for (int d = 0; d < ND; d++) begin
            was_busy  = m_busy[d];
            m_done[d] = 1'b0;
            if (data_valid && m_ready(d)) begin
                push_frame(d, data_in);
                m_busy[d] = 1'b1;
                m_nacc[d]++;
            end
            if (was_busy && tick) begin
                if (m_curlast[d] && m_len[d] == 0) begin
                    m_done[d] = 1'b1; m_busy[d] = 1'b0; m_cur[d] = 1'b1; m_curlast[d] = 1'b0;
                end else begin
                    if (m_curlast[d]) m_done[d] = 1'b1;
                    pop(d);
                end
            end
        end
    endtask

    // One clk_in cycle: model on the rising edge, compare and drive on the falling edge.
    task automatic cyc();
        logic [3:0] a, e;
        bit all_acc;
        @(posedge clk_in);
        model_step();
        @(negedge clk_in);
        for (int d = 0; d < ND; d++) begin
            a = {tone_w[d], busy_w[d], rdy_w[d], done_w[d]};
            e = {m_cur[d], m_busy[d], m_ready(d), m_done[d]};
            chk($sformatf("d%0d {tone,busy,ready,done}", d), 32'(a), 32'(e));
            obs_done[d] += int'(done_w[d]);
        end
        if (bmode == 1) begin
            bcnt = (bcnt + 1) % 4;
            baud_clk = (bcnt == 0);
        end else if (bmode == 2) begin
            baud_clk = ($urandom_range(0, 2) == 0);
        end
        if (auto_drop) begin
            all_acc = 1'b1;
            for (int d = 0; d < ND; d++) if (m_nacc[d] < acc_tgt[d]) all_acc = 1'b0;
            if (all_acc) begin
                data_valid = 1'b0;
                auto_drop  = 1'b0;
            end
        end
    endtask

    task automatic tick_wait(input string what);
        int t0, n;
        t0 = m_ticks;
        n  = 0;
        while (m_ticks == t0 && n < 64) begin cyc(); n++; end
        if (m_ticks == t0) chk({what, " tick timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        bit any;
        int n;
        n = 0;
        any = 1'b1;
        while (any && n < 400) begin
            any = 1'b0;
            for (int d = 0; d < ND; d++) if (m_busy[d]) any = 1'b1;
            if (any) begin cyc(); n++; end
        end
        if (any) chk("wait_idle timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] seq;     // bit i = d0 tone after tick i+1
        logic       par_e;
        logic       par_o;
        bit         inject;  // offer 0x3C mid-frame
    } vec_t;

    vec_t        vt [7];
    logic [9:0]  seq;
    logic [21:0] gseq;
    logic        p1, p2;
    int          dk [ND];
    int          obs0, n;

    initial begin
        vt[0] = '{8'hA5, 10'b11_0100_1010, 1'b0, 1'b1, 1'b0};
        vt[1] = '{8'h00, 10'b10_0000_0000, 1'b0, 1'b1, 1'b0};
        vt[2] = '{8'hFF, 10'b11_1111_1110, 1'b0, 1'b1, 1'b0};
        vt[3] = '{8'h01, 10'b10_0000_0010, 1'b1, 1'b0, 1'b0};
        vt[4] = '{8'h7F, 10'b10_1111_1110, 1'b1, 1'b0, 1'b0};
        vt[5] = '{8'h3C, 10'b10_0111_1000, 1'b0, 1'b1, 1'b0};
        vt[6] = '{8'hA5, 10'b11_0100_1010, 1'b0, 1'b1, 1'b1};
        n_chk = 0; n_err = 0; m_ticks = 0; bcnt = 0; bmode = 1; auto_drop = 1'b0;
        for (int d = 0; d < ND; d++) begin
            m_nacc[d] = 0; obs_done[d] = 0; acc_tgt[d] = 0; m_bits[d] = '0; m_last[d] = '0;
        end
        model_reset();

        repeat (3) cyc();
        chk("reset tone_sel", 32'(tone_w[0]), 32'd1);
        chk("reset data_ready", 32'(rdy_w[0]), 32'd1);
        chk("reset tx_busy", 32'(busy_w[0]), 32'd0);
        chk("reset frame_done", 32'(done_w[0]), 32'd0);
        reset_n = 1'b1;
        repeat (4) cyc();

        // Table-driven frames at 1-in-4 baud.
        for (int v = 0; v < 7; v++) begin
            wait_idle();
            data_in = vt[v].data; data_valid = 1'b1;
            cyc();
            data_valid = 1'b0; data_in = 8'($urandom);
            seq = '0; p1 = 1'b0; p2 = 1'b0;
            for (int d = 0; d < ND; d++) dk[d] = 0;
            for (int k = 1; k <= 12; k++) begin
                if (vt[v].inject && k == 4) begin
                    data_valid = 1'b1; data_in = 8'h3C;
                    repeat (3) cyc();
                    data_valid = 1'b0;
                end
                tick_wait("frame");
                if (k <= 10) seq[k-1] = tone_w[0];
                if (k == 10) begin p1 = tone_w[1]; p2 = tone_w[2]; end
                for (int d = 0; d < ND; d++) if (done_w[d]) dk[d] = k;
            end
            chk($sformatf("vec%0d d0 tone sequence", v), 32'(seq), 32'(vt[v].seq));
            chk($sformatf("vec%0d even parity bit", v), 32'(p1), 32'(vt[v].par_e));
            chk($sformatf("vec%0d odd parity bit", v), 32'(p2), 32'(vt[v].par_o));
            chk($sformatf("vec%0d d0 done tick", v), 32'(dk[0]), 32'd11);
            chk($sformatf("vec%0d d1 done tick", v), 32'(dk[1]), 32'd12);
            chk($sformatf("vec%0d d2 done tick", v), 32'(dk[2]), 32'd12);
            chk($sformatf("vec%0d d3 done tick", v), 32'(dk[3]), 32'd9);
            chk($sformatf("vec%0d d0 idle after", v), 32'(busy_w[0]), 32'd0);
        end

        // Accept in the same cycle as a tick: start bit waits for the next tick.
        wait_idle();
        n = 0;
        while (!(baud_clk && !m_bprev) && n < 8) begin cyc(); n++; end
        data_in = 8'hA5; data_valid = 1'b1;
        cyc();
        data_valid = 1'b0;
        chk("tick-accept no start yet", 32'(tone_w[0]), 32'd1);
        repeat (3) cyc();
        chk("tick-accept still mark", 32'(tone_w[0]), 32'd1);
        cyc();
        chk("tick-accept start bit", 32'(tone_w[0]), 32'd0);

        // Reset during data bit 3 aborts the frame immediately.
        wait_idle();
        data_in = 8'hA5; data_valid = 1'b1;
        cyc();
        data_valid = 1'b0;
        repeat (5) tick_wait("abort");
        cyc();
        reset_n = 1'b0;
        #1;
        for (int d = 0; d < ND; d++)
            chk($sformatf("d%0d async reset {tone,busy,ready,done}", d),
                32'({tone_w[d], busy_w[d], rdy_w[d], done_w[d]}), 32'b1010);
        model_reset();
        obs0 = obs_done[0];
        repeat (3) cyc();
        reset_n = 1'b1;
        repeat (50) cyc();
        chk("no done after abort", 32'(obs_done[0] - obs0), 32'd0);

        // baud_clk high across reset release, then static: frame waits forever.
        bmode = 0; baud_clk = 1'b1; reset_n = 1'b0; model_reset();
        repeat (2) cyc();
        reset_n = 1'b1; data_in = 8'h5A; data_valid = 1'b1;
        cyc();
        data_valid = 1'b0;
        repeat (20) cyc();
        chk("static baud holds busy", 32'(busy_w[0]), 32'd1);
        chk("static baud holds mark", 32'(tone_w[0]), 32'd1);
        baud_clk = 1'b0; bmode = 1;
        wait_idle();

        // Back-to-back frames with data_valid held high.
        obs0 = obs_done[0];
        for (int d = 0; d < ND; d++) acc_tgt[d] = m_nacc[d] + 2;
        auto_drop = 1'b1; data_in = 8'h01; data_valid = 1'b1;
        cyc();
        data_in = 8'h80;
        gseq = '0;
        for (int k = 1; k <= 22; k++) begin
            tick_wait("gapless");
            gseq[k-1] = tone_w[0];
        end
        if (auto_drop) begin
            chk("gapless second word accepted", 32'd0, 32'd1);
            auto_drop = 1'b0; data_valid = 1'b0;
        end
        chk("gapless d0 tone sequence", 32'(gseq), 32'(22'b1111_0000_0000_1000_0000_10));
        chk("gapless d0 done pulses", 32'(obs_done[0] - obs0), 32'd2);

        // Randomised traffic, baud, stalls and resets against the model.
        bmode = 2;
        for (int i = 0; i < 1500; i++) begin
            data_valid = ($urandom_range(0, 2) == 0);
            data_in    = 8'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                reset_n = 1'b0;
                model_reset();
            end else begin
                reset_n = 1'b1;
            end
            if ($urandom_range(0, 99) == 0) bmode = (bmode == 2) ? 0 : 2;
            cyc();
        end
        reset_n = 1'b1; data_valid = 1'b0; bmode = 1;
        wait_idle();
        repeat (4) cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fsk_bit_serializer.md
FSK_BIT_SERIALIZER -- requirements
Module: fsk_bit_serializer

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, giving the payload bits per frame (legal range 5..8).
REQ-002 The block SHALL have parameter PARITY_EN, default 0, where 1 inserts one parity bit after the payload.
REQ-003 The block SHALL have parameter PARITY_ODD, default 0, where 0 selects even parity and 1 selects odd parity; it is ignored when PARITY_EN=0.
REQ-004 The block SHALL have parameter STOP_BITS, default 1, giving the number of stop bits (legal range 1..2).
REQ-005 The block SHALL have port clk_in, input, 1 bit: system clock (6.25 MHz); all logic is clocked on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port baud_clk, input, 1 bit: baud clock from the fractional clock divider, synchronous to clk_in.
REQ-008 The block SHALL have port data_in, input, DATA_BITS wide: payload word.
REQ-009 The block SHALL have port data_valid, input, 1 bit: data_in is valid.
REQ-010 The block SHALL have port data_ready, output, 1 bit: the block can accept a word this cycle.
REQ-011 The block SHALL have port tone_sel, output, 1 bit: FSK tone select for the modulator (1 = mark, 0 = space).
REQ-012 The block SHALL have port tx_busy, output, 1 bit: a frame is pending or being transmitted.
REQ-013 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse when the last stop bit ends.

Function
REQ-014 The block SHALL register baud_clk into baud_q and derive baud_tick = baud_clk AND NOT baud_q; this is the only event that advances bit timing.
REQ-015 The FSM SHALL have the states IDLE, WAIT_TICK, START, DATA, PARITY and STOP.
REQ-016 A word SHALL be accepted only in a cycle where data_valid=1 and data_ready=1; data_in is captured into the shift register in that cycle.
REQ-017 data_ready SHALL be 1 in IDLE and during the final stop bit, and 0 in all other states.
REQ-018 When a word is accepted in IDLE, the FSM SHALL move to WAIT_TICK; a baud_tick in the acceptance cycle SHALL NOT be counted.
REQ-019 In WAIT_TICK, the next baud_tick SHALL move the FSM to START and drive tone_sel=0.
REQ-020 In START, a baud_tick SHALL move the FSM to DATA and drive tone_sel = shift-register bit 0 (payload sent LSB first).
REQ-021 In DATA, each baud_tick SHALL shift the register right and present the next bit; after DATA_BITS bits the FSM moves to PARITY (if PARITY_EN=1) or to STOP.
REQ-022 The parity bit SHALL be the XOR of the payload bits, inverted when PARITY_ODD=1.
REQ-023 In STOP, tone_sel SHALL be 1 for STOP_BITS baud periods, counted by a bit counter of width clog2(DATA_BITS+1).
REQ-024 At the baud_tick ending the final stop bit, frame_done SHALL pulse for 1 cycle, and the FSM SHALL go to START if a word was accepted during the final stop bit (gapless back-to-back), otherwise to IDLE.
REQ-025 tone_sel SHALL be registered and change exactly 1 clk_in cycle after the cycle in which baud_tick is high.
REQ-026 tone_sel SHALL be 1 in IDLE and WAIT_TICK.
REQ-027 tx_busy SHALL be 0 only in IDLE.
REQ-028 data_valid while data_ready=0 SHALL be ignored, and data_in SHALL NOT be sampled.
REQ-029 If baud_clk stays static, the FSM SHALL hold its state indefinitely with outputs stable.

Reset
REQ-030 While reset_n=0, the block SHALL asynchronously force: FSM=IDLE, tone_sel=1, data_ready=1, tx_busy=0, frame_done=0, baud_q=0, counters and shift register=0.
REQ-031 A reset_n assertion mid-frame SHALL abort the frame immediately, discard the word, and produce no frame_done pulse.
REQ-032 If baud_clk=1 at the first clk_in edge after reset release, that edge SHALL count as a baud_tick.

Verification
REQ-033 Defaults; baud_clk high 1 of every 4 clk_in cycles; send 0xA5 -> tone_sel sequence 0,1,0,1,0,0,1,0,1,1, one bit per tick, then a single frame_done pulse.
REQ-034 PARITY_EN=1, PARITY_ODD=0; send 0xA5 -> parity bit 0; with PARITY_ODD=1 -> parity bit 1; frame is 11 bits in both cases.
REQ-035 data_valid held high with 0x01 then 0x80 -> second start bit immediately follows the first stop bit with no idle mark period; 2 frame_done pulses.
REQ-036 Pulse reset_n low during data bit 3 -> tone_sel=1, tx_busy=0 and data_ready=1 within the same cycle, with no frame_done pulse.
REQ-037 Assert data_valid with 0x3C during DATA -> word ignored; the current frame completes unchanged.
REQ-038 Accept a word in the same cycle as a baud_tick -> the start bit begins only at the following tick.
